// File: rtl/psg_write_queue.sv
// Write queue feeding an SN76489-style PSG: FIFO of command bytes, PSG clock-enable
// divider and nCE/nWE/D replay FSM. Optional READY timeout under PSG_WQ_TIMEOUT_EN.
module psg_write_queue #(
  parameter int DEPTH      = 8,
  parameter int DIV        = 28,
  parameter int HOLD_TICKS = 2
) (
  input  logic                     CLK100MHZ,
  input  logic                     CPU_RESETN,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     PSG_CLK,
  output logic                     nCE,
  output logic                     nWE,
  output logic [7:0]               D,
  input  logic                     READY,
`ifdef PSG_WQ_TIMEOUT_EN
  output logic                     timeout,
`endif
  output logic [1:0]               state
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETUP   = 2'd1;
  localparam logic [1:0] S_STROBE  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [CW-1:0] div_cnt;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [HW-1:0] hold_cnt;
  logic          push;
  logic          pop;
`ifdef PSG_WQ_TIMEOUT_EN
  logic [15:0]   to_cnt;
`endif

  // Free-running divider; PSG_CLK is high for the single cycle after the wrap point.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div_cnt <= '0;
      PSG_CLK <= 1'b0;
    end else begin
      PSG_CLK <= (div_cnt == CW'(DIV - 1));
      div_cnt <= (div_cnt == CW'(DIV - 1)) ? '0 : div_cnt + CW'(1);
    end
  end

  // Handshake: wr_en is a one-cycle push with no back-pressure. It is accepted when the
  // FIFO has room or the FSM pops in the same cycle; otherwise it is dropped and overflow latches.
  assign pop   = (state == S_IDLE) && (level != '0);
  assign push  = wr_en && (!full || pop);
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0) && (state == S_IDLE);

  always_ff @(posedge CLK100MHZ) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (wr_en && !push) overflow <= 1'b1;
    end
  end

  // Outputs are registered alongside the state so nCE/nWE never glitch.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= S_IDLE;
      nCE      <= 1'b1;
      nWE      <= 1'b1;
      D        <= 8'h00;
      hold_cnt <= '0;
`ifdef PSG_WQ_TIMEOUT_EN
      to_cnt   <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            D     <= mem[rd_ptr];
            nCE   <= 1'b0;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (PSG_CLK) begin
            nWE      <= 1'b0;
            hold_cnt <= '0;
            state    <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (PSG_CLK) begin
            if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
              nCE   <= 1'b1;
              nWE   <= 1'b1;
              state <= S_RELEASE;
`ifdef PSG_WQ_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        S_RELEASE: begin
          if (PSG_CLK) begin
            if (READY) begin
              state <= S_IDLE;
`ifdef PSG_WQ_TIMEOUT_EN
            end else if (to_cnt == 16'd1023) begin
              state   <= S_IDLE;
              timeout <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 16'd1;
`endif
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psg_write_queue.sv
// Directed bench for psg_write_queue: reset, divider, write timing, overflow,
// push-during-pop, READY stall, mid-write reset (plus timeout when PSG_WQ_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_psg_write_queue;
  localparam int DEPTH   = 8;
  localparam int DIV     = 28;
  localparam int HOLD    = 2;
  localparam int WR_LEN  = HOLD * DIV;
  localparam int SPACING = (HOLD + 2) * DIV;
  localparam logic [1:0] S_IDLE = 2'd0, S_SETUP = 2'd1, S_STROBE = 2'd2, S_RELEASE = 2'd3;

  logic       CLK100MHZ = 1'b0;
  logic       CPU_RESETN = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       READY = 1'b1;
  logic       full, empty, overflow, PSG_CLK, nCE, nWE;
  logic [3:0] level;
  logic [7:0] D;
  logic [1:0] state;
`ifdef PSG_WQ_TIMEOUT_EN
  logic       timeout;
`endif

  psg_write_queue #(.DEPTH(DEPTH), .DIV(DIV), .HOLD_TICKS(HOLD)) dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .PSG_CLK(PSG_CLK),
    .nCE(nCE), .nWE(nWE), .D(D), .READY(READY),
`ifdef PSG_WQ_TIMEOUT_EN
    .timeout(timeout),
`endif
    .state(state)
  );

  // clock / cycle counter
  always #5 CLK100MHZ = ~CLK100MHZ;
  int cyc = 0;
  always @(posedge CLK100MHZ) cyc++;

  int checks = 0;
  int errors = 0;

  // write monitor and expected queue
  logic [7:0] exp_q[$];
  logic [7:0] obs_d[$];
  int         obs_len[$];
  int         obs_start[$];
  logic [7:0] cur_d = 8'h00;
  logic       prev_nwe = 1'b1, prev_nce = 1'b1;
  int         low_len = 0, nce_falls = 0, nce_bad = 0, d_bad = 0;

  always @(negedge CLK100MHZ) begin
    if (prev_nce && !nCE) nce_falls++;
    if (!nWE && nCE) nce_bad++;
    if (prev_nwe && !nWE) begin
      obs_d.push_back(D);
      obs_start.push_back(cyc);
      cur_d = D;
      low_len = 1;
    end else if (!nWE) begin
      low_len++;
      if (D !== cur_d) d_bad++;
    end else if (!prev_nwe) begin
      obs_len.push_back(low_len);
    end
    prev_nwe = nWE;
    prev_nce = nCE;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic clear_mon();
    obs_d.delete(); obs_len.delete(); obs_start.delete(); exp_q.delete();
    nce_falls = 0; nce_bad = 0; d_bad = 0;
  endtask

  task automatic do_reset();
    CPU_RESETN = 1'b0; wr_en = 1'b0; wr_data = 8'h00; READY = 1'b1;
    repeat (3) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    clear_mon();
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    @(negedge CLK100MHZ);
    wr_en = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      if (state === s) ok = 1'b1;
      else @(negedge CLK100MHZ);
    end
  endtask

  task automatic wait_writes(input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      if (obs_len.size() >= n) ok = 1'b1;
      else @(negedge CLK100MHZ);
    end
  endtask

  task automatic test_reset();
    int pulses = 0, dbl = 0, gap_bad = 0, busy = 0, last = -1;
    logic prev = 1'b0;
    do_reset();
    @(negedge CLK100MHZ);
    checks++; if ({nCE, nWE} !== 2'b11) begin errors++; $display("FAIL reset_nce_nwe got %b exp 11", {nCE, nWE}); end
    checks++; if (D !== 8'h00) begin errors++; $display("FAIL reset_d got %h exp 00", D); end
    checks++; if ({empty, full, overflow} !== 3'b100) begin errors++; $display("FAIL reset_flags got %b exp 100", {empty, full, overflow}); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    for (int i = 0; i < 280; i++) begin
      @(negedge CLK100MHZ);
      if (PSG_CLK === 1'b1) begin
        pulses++;
        if (prev) dbl++;
        if (last >= 0 && cyc - last != DIV) gap_bad++;
        last = cyc;
      end
      prev = PSG_CLK;
      if (nCE !== 1'b1 || nWE !== 1'b1 || empty !== 1'b1) busy++;
    end
    checks++; if (pulses != 10) begin errors++; $display("FAIL div_pulses got %0d exp 10", pulses); end
    checks++; if (dbl != 0 || gap_bad != 0) begin errors++; $display("FAIL div_spacing got dbl=%0d gap_bad=%0d exp 0/0", dbl, gap_bad); end
    checks++; if (busy != 0) begin errors++; $display("FAIL idle_quiet got %0d busy cycles exp 0", busy); end
  endtask

  task automatic test_two_writes();
    bit ok;
    READY = 1'b1;
    wr_en = 1'b1; wr_data = 8'h89;
    @(negedge CLK100MHZ);
    checks++; if (level !== 4'd1 || D !== 8'h00) begin errors++; $display("FAIL lat_first got level=%0d D=%h exp 1/00", level, D); end
    wr_data = 8'h3F;
    @(negedge CLK100MHZ);
    wr_en = 1'b0;
    checks++; if (D !== 8'h89 || nCE !== 1'b0 || nWE !== 1'b1 || state !== S_SETUP) begin
      errors++; $display("FAIL lat_load got D=%h nCE=%b nWE=%b st=%0d exp 89/0/1/1", D, nCE, nWE, state); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL push_pop_level got %0d exp 1", level); end
    wait_writes(2, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL two_writes_done got %0d writes exp 2", obs_len.size()); end
    if (ok) begin
      checks++; if (obs_d[0] !== 8'h89 || obs_d[1] !== 8'h3F) begin errors++; $display("FAIL two_writes_data got %h %h exp 89 3F", obs_d[0], obs_d[1]); end
      checks++; if (obs_len[0] != WR_LEN || obs_len[1] != WR_LEN) begin errors++; $display("FAIL nwe_width got %0d %0d exp %0d", obs_len[0], obs_len[1], WR_LEN); end
      checks++; if (obs_start[1] - obs_start[0] != SPACING) begin errors++; $display("FAIL write_spacing got %0d exp %0d", obs_start[1] - obs_start[0], SPACING); end
    end
    checks++; if (nce_bad != 0 || d_bad != 0) begin errors++; $display("FAIL strobe_frame got nce_bad=%0d d_bad=%0d exp 0/0", nce_bad, d_bad); end
    wait_state(S_IDLE, 200, ok);
    @(negedge CLK100MHZ);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drained_empty got %b exp 1", empty); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    READY = 1'b0;
    push_byte(8'hA0); exp_q.push_back(8'hA0);
    wait_state(S_RELEASE, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_stall got state %0d exp 3", state); end
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(8'h10 + 8'(i)); exp_q.push_back(8'h10 + 8'(i));
    end
    checks++; if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_fill got full=%b level=%0d ovf=%b exp 1/8/0", full, level, overflow); end
    push_byte(8'hEE);
    checks++; if (overflow !== 1'b1 || level !== 4'd8) begin errors++; $display("FAIL ovf_drop got ovf=%b level=%0d exp 1/8", overflow, level); end
    READY = 1'b1;
    wait_writes(9, 3000, ok);
    repeat (300) @(negedge CLK100MHZ);
    checks++; if (obs_d.size() != 9) begin errors++; $display("FAIL ovf_count got %0d exp 9", obs_d.size()); end
    for (int i = 0; i < 9 && i < obs_d.size(); i++) begin
      checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_order[%0d] got %h exp %h", i, obs_d[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL ovf_sticky got ovf=%b empty=%b exp 1/1", overflow, empty); end
  endtask

  task automatic test_full_pop_push();
    bit ok;
    do_reset();
    READY = 1'b0;
    push_byte(8'hA0); exp_q.push_back(8'hA0);
    wait_state(S_RELEASE, 300, ok);
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(8'h20 + 8'(i)); exp_q.push_back(8'h20 + 8'(i));
    end
    READY = 1'b1;
    wait_state(S_IDLE, 200, ok);
    checks++; if (!ok || level !== 4'd8) begin errors++; $display("FAIL fpp_setup got st=%0d level=%0d exp 0/8", state, level); end
    wr_en = 1'b1; wr_data = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge CLK100MHZ);
    wr_en = 1'b0;
    checks++; if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL fpp_level got level=%0d full=%b ovf=%b exp 8/1/0", level, full, overflow); end
    wait_writes(10, 3000, ok);
    checks++; if (obs_d.size() != 10) begin errors++; $display("FAIL fpp_count got %0d exp 10", obs_d.size()); end
    for (int i = 0; i < 10 && i < obs_d.size(); i++) begin
      checks++; if (obs_d[i] !== exp_q[i]) begin errors++; $display("FAIL fpp_order[%0d] got %h exp %h", i, obs_d[i], exp_q[i]); end
    end
  endtask

  task automatic test_ready_stall();
    bit ok;
    int p = 0, bad = 0, t0;
    do_reset();
    READY = 1'b0;
    push_byte(8'h90);
    push_byte(8'h91);
    wait_state(S_RELEASE, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_release got state %0d exp 3", state); end
    for (int g = 0; g < 2000 && p < 40; g++) begin
      @(negedge CLK100MHZ);
      if (PSG_CLK === 1'b1) p++;
      if (state !== S_RELEASE || nCE !== 1'b1 || D !== 8'h90) bad++;
    end
    checks++; if (p != 40 || bad != 0) begin errors++; $display("FAIL stall_hold got pulses=%0d bad=%0d exp 40/0", p, bad); end
    checks++; if (nce_falls != 1 || level !== 4'd1) begin errors++; $display("FAIL stall_nce got falls=%0d level=%0d exp 1/1", nce_falls, level); end
    t0 = cyc;
    READY = 1'b1;
    wait_writes(2, 1000, ok);
    checks++; if (!ok || obs_d[1] !== 8'h91 || obs_start[1] <= t0) begin
      errors++; $display("FAIL stall_resume got ok=%b writes=%0d exp second 91 after cycle %0d", ok, obs_d.size(), t0); end
  endtask

`ifdef PSG_WQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int p = 0;
    do_reset();
    READY = 1'b0;
    push_byte(8'hC3);
    wait_state(S_RELEASE, 300, ok);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", timeout); end
    for (int g = 0; g < 40000 && state === S_RELEASE; g++) begin
      if (PSG_CLK === 1'b1) p++;
      @(negedge CLK100MHZ);
    end
    checks++; if (state !== S_IDLE || timeout !== 1'b1 || p != 1024) begin
      errors++; $display("FAIL to_fire got st=%0d to=%b pulses=%0d exp 0/1/1024", state, timeout, p); end
    READY = 1'b1;
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    READY = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'h31 + 8'(i));
    wait_state(S_STROBE, 300, ok);
    checks++; if (!ok || level !== 4'd3 || nWE !== 1'b0) begin errors++; $display("FAIL mid_setup got st=%0d level=%0d nWE=%b exp 2/3/0", state, level, nWE); end
    #2 CPU_RESETN = 1'b0;
    #1;
    checks++; if ({nCE, nWE} !== 2'b11 || level !== 4'd0 || empty !== 1'b1 || state !== S_IDLE) begin
      errors++; $display("FAIL mid_async got nCE=%b nWE=%b level=%0d empty=%b st=%0d exp 1/1/0/1/0", nCE, nWE, level, empty, state); end
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    clear_mon();
    repeat (400) @(negedge CLK100MHZ);
    checks++; if (nce_falls != 0 || obs_d.size() != 0 || empty !== 1'b1) begin
      errors++; $display("FAIL mid_stale got falls=%0d writes=%0d empty=%b exp 0/0/1", nce_falls, obs_d.size(), empty); end
  endtask

  initial begin
    test_reset();
    test_two_writes();
    test_overflow();
    test_full_pop_push();
    test_ready_stall();
`ifdef PSG_WQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
